// File: rtl/apb_sram_pkg.sv
// Shared types and elaboration-time parameter checks for the APB SRAM slave.
package apb_sram_pkg;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    localparam int unsigned WaitW = 4;

    function automatic bit data_w_ok(int unsigned data_w);
        return (data_w > 0) && (data_w % 8 == 0);
    endfunction

    function automatic bit depth_ok(int unsigned depth, int unsigned addr_w);
        return (depth > 0) && (64'(depth) <= (64'd1 << addr_w));
    endfunction

    function automatic bit wait_ok(int unsigned wait_cyc);
        return wait_cyc <= (2 ** WaitW) - 1;
    endfunction

    function automatic bit ro_ok(int unsigned ro_limit, int unsigned depth);
        return ro_limit <= depth;
    endfunction

    function automatic bit params_ok(int unsigned data_w, int unsigned addr_w,
                                     int unsigned depth, int unsigned wait_cyc,
                                     int unsigned ro_limit);
        return data_w_ok(data_w) && depth_ok(depth, addr_w) && wait_ok(wait_cyc)
            && ro_ok(ro_limit, depth);
    endfunction

endpackage

// File: rtl/apb_sram_array.sv
// Word-organised storage: combinational read, byte-lane-enabled synchronous write.
module apb_sram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   strb_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(DATA_W / 8); i++) begin
                if (strb_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/apb_sram_slave.sv
// APB slave fronting a byte-writable SRAM with configurable wait states and
// a read-only region at the bottom of the address space.
module apb_sram_slave
    import apb_sram_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned RO_LIMIT = 0
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic                  pwrite_i,
    input  logic [DATA_W-1:0]     pwdata_i,
    input  logic [DATA_W/8-1:0]   pstrb_i,
    output logic [DATA_W-1:0]     prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    if (!params_ok(DATA_W, ADDR_W, DEPTH, WAIT_CYC, RO_LIMIT)) begin : g_param_err
        $error("apb_sram_slave: illegal parameter combination");
    end

    localparam int unsigned StrbW = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] RoA    = (ADDR_W + 1)'(RO_LIMIT);

    state_e              state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [StrbW-1:0]    strb_q;

    logic                capture;
    logic                done;
    logic                err;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    assign capture = (state_d == StSetup);
    assign done    = (state_q == StAccess) && (wait_q == '0);
    assign err     = ({1'b0, addr_q} >= DepthA) || (write_q && ({1'b0, addr_q} < RoA));

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (psel_i && !penable_i) state_d = StSetup;
            StSetup:  state_d = psel_i ? StAccess : StIdle;
            StAccess: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (wait_q == '0) begin
                    state_d = !penable_i ? StSetup : StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        pready_o  = done;
        pslverr_o = done && err;
        prdata_o  = (done && !write_q && !err) ? mem_rdata : '0;
        mem_we    = done && write_q && !err;
    end

    always_comb begin
        wait_d = wait_q;
        if (capture) begin
            wait_d = WaitW'(WAIT_CYC);
        end else if ((state_q == StAccess) && (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            wait_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            wait_q <= wait_d;
            if (capture) begin
                addr_q  <= paddr_i;
                write_q <= pwrite_i;
                wdata_q <= pwdata_i;
                strb_q  <= pstrb_i;
            end
        end
    end

    apb_sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (pclk_i),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .strb_i  (strb_q),
        .rdata_o (mem_rdata)
    );

endmodule
